// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame size and common mouse command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    RELEASE,
    DONE
  } state_t;

  localparam int FRAME_BITS = 10;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_DEFAULTS = 8'hF6;

  // Frame after the start bit, LSB first: data, odd parity, stop.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_in_sync.sv
// PS/2 clock/data synchroniser with falling-edge detect on the synchronised clock.
module ps2_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic clk_sync,
  output logic dat_sync,
  output logic fall
);

  logic [SYNC_STAGES-1:0] clk_sr;
  logic [SYNC_STAGES-1:0] dat_sr;
  logic                   clk_prev;

  // Reset to the idle-high line level so leaving reset never fakes a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sr   <= '1;
      dat_sr   <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sr   <= {clk_sr[SYNC_STAGES-2:0], ps2_clk};
      dat_sr   <= {dat_sr[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_sr[SYNC_STAGES-1];
    end
  end

  assign clk_sync = clk_sr[SYNC_STAGES-1];
  assign dat_sync = dat_sr[SYNC_STAGES-1];
  assign fall     = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, shift, ACK check).
// Optional device-silence timeout is enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iStart,
  input  logic [7:0] iData,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DAT,
  output logic       oPS2_CLK_oe,
  output logic       oPS2_DAT_oe,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [3:0]            bit_idx, bit_idx_nx;
  logic                  nack, nack_nx;
  logic [FRAME_BITS-1:0] frame;
  logic                  clk_s, dat_s, fall;
  logic                  timed_out;

  ps2_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (iClk),
    .rst      (iReset),
    .ps2_clk  (iPS2_CLK),
    .ps2_dat  (iPS2_DAT),
    .clk_sync (clk_s),
    .dat_sync (dat_s),
    .fall     (fall)
  );

`ifdef PS2_TX_TIMEOUT_EN
  assign timed_out = (cnt == '0) && ((state == SEND) || (state == ACK) || (state == RELEASE));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      nack    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      nack    <= nack_nx;
    end
  end

  always_ff @(posedge iClk) begin
    if (state == IDLE && iStart) frame <= make_frame(iData);
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    bit_idx_nx  = bit_idx;
    nack_nx     = nack;
    oPS2_CLK_oe = 1'b0;
    oPS2_DAT_oe = 1'b0;
    oBusy       = 1'b1;
    oDone       = 1'b0;
    oError      = 1'b0;
    case (state)
      IDLE: begin
        oBusy = 1'b0;
        if (iStart) begin
          state_nx   = INHIBIT;
          cnt_nx     = CNT_W'(INHIBIT_CYCLES - 1);
          bit_idx_nx = '0;
          nack_nx    = 1'b0;
        end
      end
      INHIBIT: begin
        oPS2_CLK_oe = 1'b1;
        if (cnt == '0) state_nx = RTS;
      end
      RTS: begin
        oPS2_CLK_oe = 1'b1;
        oPS2_DAT_oe = 1'b1;
        state_nx    = SEND;
        bit_idx_nx  = '0;
`ifdef PS2_TX_TIMEOUT_EN
        cnt_nx      = CNT_W'(TIMEOUT_CYCLES);
`endif
      end
      SEND: begin
        // Index 0 is still the start bit; fall n exposes frame bit n-1.
        oPS2_DAT_oe = (bit_idx == 4'd0) ? 1'b1 : ~frame[bit_idx - 4'd1];
        if (fall) begin
          bit_idx_nx = bit_idx + 4'd1;
`ifdef PS2_TX_TIMEOUT_EN
          cnt_nx     = CNT_W'(TIMEOUT_CYCLES);
`endif
          if (bit_idx == 4'(FRAME_BITS - 1)) state_nx = ACK;
        end
      end
      ACK: begin
        if (fall) begin
          nack_nx  = dat_s;
          state_nx = RELEASE;
`ifdef PS2_TX_TIMEOUT_EN
          cnt_nx   = CNT_W'(TIMEOUT_CYCLES);
`endif
        end
      end
      RELEASE: begin
        if (clk_s && dat_s) state_nx = DONE;
      end
      DONE: begin
        oBusy    = 1'b0;
        oDone    = 1'b1;
        oError   = nack;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Silent device: drop both lines now, report the failure next cycle.
    if (timed_out) begin
      oPS2_CLK_oe = 1'b0;
      oPS2_DAT_oe = 1'b0;
      nack_nx     = 1'b1;
      state_nx    = DONE;
    end
  end

endmodule
